// File: rtl/risc_v_mike_pkg.sv
// Shared types and default memory map for the load/store bus controller.
// Regions: text, data, stack and MMIO with per-region base/mask pairs.
package risc_v_mike_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERR,
    S_RESP
  } mem_bus_state_t;

  localparam int WAIT_W = 4;

  localparam logic [31:0] MEM_TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] MEM_TEXT_MASK  = 32'hFFC0_0000;
  localparam logic [31:0] MEM_DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] MEM_DATA_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] MEM_STACK_BASE = 32'h7FFF_0000;
  localparam logic [31:0] MEM_STACK_MASK = 32'hFFFF_0000;
  localparam logic [31:0] MEM_MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] MEM_MMIO_MASK  = 32'hFFFF_0000;

endpackage

// File: rtl/risc_v_mem_addr_decode.sv
// Combinational region decoder: priority one-hot hit vector and
// the region-local offset of the winning region.
module risc_v_mem_addr_decode #(
  parameter int N_REG  = 4,
  parameter int ADDR_W = 32,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_REG-1:0]  hit_vec,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  logic [ADDR_W-1:0] base_i;
  logic [ADDR_W-1:0] mask_i;

  // Ascending scan; the first match blocks later ones (lowest wins).
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    offset  = '0;
    base_i  = '0;
    mask_i  = '0;
    for (int i = 0; i < N_REG; i++) begin
      base_i = REG_BASE[i*ADDR_W +: ADDR_W];
      mask_i = REG_MASK[i*ADDR_W +: ADDR_W];
      if (!hit && ((addr & mask_i) == (base_i & mask_i))) begin
        hit        = 1'b1;
        hit_vec[i] = 1'b1;
        offset     = addr & ~mask_i;
      end
    end
  end

endmodule

// File: rtl/risc_v_mem_bus_ctrl.sv
// Single-outstanding memory-bus controller with region decode,
// per-region wait states and error response for holes/misalignment.
module risc_v_mem_bus_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int N_REG  = 4,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE =
    {MEM_MMIO_BASE, MEM_STACK_BASE, MEM_DATA_BASE, MEM_TEXT_BASE},
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK =
    {MEM_MMIO_MASK, MEM_STACK_MASK, MEM_DATA_MASK, MEM_TEXT_MASK},
  parameter logic [N_REG*WAIT_W-1:0] REG_WAIT =
    {4'd2, 4'd0, 4'd1, 4'd0}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [N_REG-1:0]        reg_sel,
  output logic                    reg_we,
  output logic                    reg_re,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [DATA_W-1:0]       reg_wdata,
  input  logic [N_REG*DATA_W-1:0] reg_rdata
);

  mem_bus_state_t state_q, state_d;

  logic              write_q;
  logic [N_REG-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [N_REG-1:0]  hit_vec;
  logic              hit;
  logic [ADDR_W-1:0] offset;
  logic              ok;
  logic [WAIT_W-1:0] wait_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic              accept;

  risc_v_mem_addr_decode #(
    .N_REG   (N_REG),
    .ADDR_W  (ADDR_W),
    .REG_BASE(REG_BASE),
    .REG_MASK(REG_MASK)
  ) u_decode (
    .addr   (req_addr),
    .hit_vec(hit_vec),
    .hit    (hit),
    .offset (offset)
  );

  assign ok     = hit && (req_addr[1:0] == 2'b00);
  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    wait_sel  = '0;
    rdata_sel = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (hit_vec[i])
        wait_sel = wait_sel | REG_WAIT[i*WAIT_W +: WAIT_W];
      if (sel_q[i])
        rdata_sel = rdata_sel | reg_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // rdata_q is cleared on accept so writes and errors respond with 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      sel_q   <= ok ? hit_vec : '0;
      addr_q  <= offset;
      wdata_q <= req_wdata;
      cnt_q   <= ok ? wait_sel : '0;
      err_q   <= !ok;
      rdata_q <= '0;
    end else if (state_q == S_ACCESS) begin
      if (cnt_q == '0) begin
        if (!write_q) rdata_q <= rdata_sel;
      end else begin
        cnt_q <= cnt_q - WAIT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    reg_sel   = '0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ok ? S_ACCESS : S_ERR;
      end
      S_ACCESS: begin
        reg_sel   = sel_q;
        reg_we    = write_q;
        reg_re    = !write_q;
        reg_addr  = addr_q;
        reg_wdata = wdata_q;
        if (cnt_q == '0) state_d = S_RESP;
      end
      S_ERR: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_v_mem_bus_ctrl.sv
// Directed bench for the memory-bus controller: decode, wait states,
// errors, back-to-back handshakes and reset during an access.
module tb_risc_v_mem_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   reg_sel;
  logic         reg_we;
  logic         reg_re;
  logic [31:0]  reg_addr;
  logic [31:0]  reg_wdata;
  logic [127:0] reg_rdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  risc_v_mem_bus_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .reg_sel  (reg_sel),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  // Issue one request at a negedge (cycle 0) and observe 7 more cycles.
  task automatic run_req(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic        rdy0,
    output int          rsp_n,
    output int          rsp_cnt,
    output int          we_cnt,
    output int          re_cnt,
    output int          rdy_n,
    output logic [3:0]  sel_or,
    output logic [31:0] addr_s,
    output logic [31:0] wdata_s,
    output logic [31:0] rdata_s,
    output logic        err_s,
    output logic        both
  );
    @(negedge clk);
    rdy0 = req_ready;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_n = -1; rsp_cnt = 0; we_cnt = 0; re_cnt = 0; rdy_n = -1;
    sel_or = '0; addr_s = '0; wdata_s = '0; rdata_s = '0;
    err_s = 1'b0; both = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (reg_we) we_cnt++;
      if (reg_re) re_cnt++;
      if (reg_we && reg_re) both = 1'b1;
      if (reg_sel != 4'b0) begin
        sel_or  = sel_or | reg_sel;
        addr_s  = reg_addr;
        wdata_s = reg_wdata;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_n   = n;
        rdata_s = rsp_rdata;
        err_s   = rsp_err;
      end
      if (req_ready && rdy_n < 0) rdy_n = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
    else pass_cnt++;
    total++;
    if ({rsp_valid, rsp_err, reg_we, reg_re, reg_sel} !== 8'h00)
      $display("FAIL reset_ctrl: got %h want 00",
               {rsp_valid, rsp_err, reg_we, reg_re, reg_sel});
    else pass_cnt++;
    total++;
    if ({reg_addr, reg_wdata, rsp_rdata} !== 96'h0)
      $display("FAIL reset_data: got %h want 0", {reg_addr, reg_wdata, rsp_rdata});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_text_read();
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    run_req(1'b0, 32'h0040_0004, 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (so !== 4'b0001 || as !== 32'h4)
      $display("FAIL text_sel_addr: got sel=%b addr=%h want 0001/4", so, as);
    else pass_cnt++;
    total++;
    if (rcn != 1 || wc != 0)
      $display("FAIL text_re_len: got re=%0d we=%0d want 1/0", rcn, wc);
    else pass_cnt++;
    total++;
    if (rn != 2 || rc != 1)
      $display("FAIL text_latency: got cyc=%0d cnt=%0d want 2/1", rn, rc);
    else pass_cnt++;
    total++;
    if (rs !== 32'hDEAD_BEEF || er !== 1'b0)
      $display("FAIL text_rdata: got %h err=%b want deadbeef/0", rs, er);
    else pass_cnt++;
  endtask

  task automatic test_data_write();
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    run_req(1'b1, 32'h1001_0000, 32'h1234_5678, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (so !== 4'b0010 || as !== 32'h0)
      $display("FAIL data_sel_addr: got sel=%b addr=%h want 0010/0", so, as);
    else pass_cnt++;
    total++;
    if (wc != 2 || rcn != 0 || bo !== 1'b0)
      $display("FAIL data_we_len: got we=%0d re=%0d both=%b want 2/0/0", wc, rcn, bo);
    else pass_cnt++;
    total++;
    if (ws !== 32'h1234_5678)
      $display("FAIL data_wdata: got %h want 12345678", ws);
    else pass_cnt++;
    total++;
    if (rn != 3 || rs !== 32'h0 || er !== 1'b0)
      $display("FAIL data_rsp: got cyc=%0d rdata=%h err=%b want 3/0/0", rn, rs, er);
    else pass_cnt++;
  endtask

  task automatic test_mmio_read();
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    run_req(1'b0, 32'hFFFF_0010, 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (so !== 4'b1000 || as !== 32'h10)
      $display("FAIL mmio_sel_addr: got sel=%b addr=%h want 1000/10", so, as);
    else pass_cnt++;
    total++;
    if (rcn != 3)
      $display("FAIL mmio_re_len: got %0d want 3", rcn);
    else pass_cnt++;
    total++;
    if (rn != 4 || rs !== 32'hCAFE_F00D)
      $display("FAIL mmio_rsp: got cyc=%0d rdata=%h want 4/cafef00d", rn, rs);
    else pass_cnt++;
    total++;
    if (r0 !== 1'b1 || yn != 5)
      $display("FAIL mmio_ready: got rdy0=%b back_at=%0d want 1/5", r0, yn);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    addrs[0] = 32'h0000_0000;
    addrs[1] = 32'h0000_0100;
    addrs[2] = 32'h10F1_0000;
    addrs[3] = 32'h7FFF_EFFE;
    for (int k = 0; k < 4; k++) begin
      run_req(1'b0, addrs[k], 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
      total++;
      if (so !== 4'b0 || wc != 0 || rcn != 0)
        $display("FAIL err_strobe %h: got sel=%b we=%0d re=%0d want none",
                 addrs[k], so, wc, rcn);
      else pass_cnt++;
      total++;
      if (rn != 2 || rc != 1 || er !== 1'b1 || rs !== 32'h0)
        $display("FAIL err_rsp %h: got cyc=%0d cnt=%0d err=%b rdata=%h want 2/1/1/0",
                 addrs[k], rn, rc, er, rs);
      else pass_cnt++;
    end
  endtask

  task automatic test_region_edge();
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    run_req(1'b0, 32'h7FFF_FFFC, 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (so !== 4'b0100 || as !== 32'hFFFC || er !== 1'b0 || rs !== 32'h5555_AAAA)
      $display("FAIL edge_last: got sel=%b addr=%h err=%b rdata=%h want 0100/fffc/0/5555aaaa",
               so, as, er, rs);
    else pass_cnt++;
    run_req(1'b0, 32'h8000_0000, 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (so !== 4'b0 || er !== 1'b1 || rn != 2)
      $display("FAIL edge_past: got sel=%b err=%b cyc=%0d want 0/1/2", so, er, rn);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc_n [2];
    int acc_cnt, rsp_cnt;
    int rsp_at [2];
    logic [31:0] a1, a4, rd;
    acc_cnt = 0; rsp_cnt = 0;
    acc_n[0] = -1; acc_n[1] = -1;
    rsp_at[0] = -1; rsp_at[1] = -1;
    a1 = '0; a4 = '0; rd = '0;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 32'h7FFF_EFFC;
    req_valid = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) @(negedge clk);
      if (rsp_valid) begin
        if (rsp_cnt < 2) rsp_at[rsp_cnt] = n;
        rsp_cnt++;
        rd = rsp_rdata;
      end
      if (n == 1) a1 = reg_addr;
      if (n == 4) a4 = reg_addr;
      if (req_valid && req_ready) begin
        if (acc_cnt < 2) acc_n[acc_cnt] = n;
        acc_cnt++;
      end
      if (n == 1) req_addr = 32'h7FFF_E000;
      if (acc_cnt == 2 && n > acc_n[1]) req_valid = 1'b0;
      if (n == acc_n[1] && acc_cnt == 2) req_valid = 1'b1;
    end
    req_valid = 1'b0;
    total++;
    if (acc_cnt != 2 || acc_n[0] != 0 || acc_n[1] != 3)
      $display("FAIL b2b_accept: got cnt=%0d at %0d,%0d want 2 at 0,3",
               acc_cnt, acc_n[0], acc_n[1]);
    else pass_cnt++;
    total++;
    if (a1 !== 32'hEFFC || a4 !== 32'hE000)
      $display("FAIL b2b_addr: got %h,%h want effc,e000", a1, a4);
    else pass_cnt++;
    total++;
    if (rsp_cnt != 2 || rsp_at[0] != 2 || rsp_at[1] != 5 || rd !== 32'h5555_AAAA)
      $display("FAIL b2b_rsp: got cnt=%0d at %0d,%0d rdata=%h want 2 at 2,5",
               rsp_cnt, rsp_at[0], rsp_at[1], rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int late_rsp;
    logic r0, er, bo; int rn, rc, wc, rcn, yn;
    logic [3:0] so; logic [31:0] as, ws, rs;
    late_rsp = 0;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 32'hFFFF_0020;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (reg_re !== 1'b1 || reg_sel !== 4'b1000)
      $display("FAIL rst_pre: got re=%b sel=%b want 1/1000", reg_re, reg_sel);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({reg_sel, reg_we, reg_re, rsp_valid} !== 7'b0 || req_ready !== 1'b1)
      $display("FAIL rst_abort: got sel=%b we=%b re=%b rsp=%b rdy=%b want 0/0/0/0/1",
               reg_sel, reg_we, reg_re, rsp_valid, req_ready);
    else pass_cnt++;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rsp_valid) late_rsp++;
    end
    total++;
    if (late_rsp != 0)
      $display("FAIL rst_no_rsp: got %0d pulses want 0", late_rsp);
    else pass_cnt++;
    run_req(1'b0, 32'h0040_0004, 32'h0, r0, rn, rc, wc, rcn, yn, so, as, ws, rs, er, bo);
    total++;
    if (rn != 2 || rs !== 32'hDEAD_BEEF || er !== 1'b0 || so !== 4'b0001)
      $display("FAIL rst_recover: got cyc=%0d rdata=%h err=%b sel=%b want 2/deadbeef/0/0001",
               rn, rs, er, so);
    else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    reg_rdata = {32'hCAFE_F00D, 32'h5555_AAAA, 32'h1111_2222, 32'hDEAD_BEEF};
    test_reset();
    test_text_read();
    test_data_write();
    test_mmio_read();
    test_errors();
    test_region_edge();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
